mod_exp_ctrl: RTL and testbench

Left-to-right square-and-multiply sequencer that computes base^exp mod m.
It sits directly upstream of the interleaved modular multiplier (mod_mul_il_v2). It issues every squaring and multiplication to that multiplier and consumes each product before issuing the next operation.
The block owns the operand registers and the exponent scan. It returns the final residue with a one-cycle done pulse.

---
 rtl/mod_mul_pkg.sv | 22 ++
 rtl/mod_exp_ctrl.sv | 175 +++++++++++++++++
 tb/tb_mod_exp_ctrl.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mod_mul_pkg.sv
// Shared types and width constants for the modular exponentiation controller
// and the interleaved modular multiplier it drives.
package mod_mul_pkg;

  localparam int NBITS_DEF = 4096;
  localparam int EBITS_DEF = 4096;
  localparam int CBITS_DEF = $clog2(EBITS_DEF);

  localparam logic [NBITS_DEF-1:0] ONE_NBITS = {{(NBITS_DEF-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CHECK    = 3'd1,
    ST_SCAN     = 3'd2,
    ST_SQR_GO   = 3'd3,
    ST_SQR_WAIT = 3'd4,
    ST_MUL_GO   = 3'd5,
    ST_MUL_WAIT = 3'd6,
    ST_FIN      = 3'd7
  } state_e;

endpackage

// File: rtl/mod_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer: computes base^exp mod m by
// issuing one squaring or multiplication at a time to an external multiplier.
module mod_exp_ctrl
  import mod_mul_pkg::*;
#(
  parameter int NBITS = NBITS_DEF,
  parameter int EBITS = EBITS_DEF,
  parameter int CBITS = CBITS_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_p,
  input  logic [NBITS-1:0] base,
  input  logic [EBITS-1:0] exp,
  input  logic [NBITS-1:0] m,
  output logic [NBITS-1:0] result,
  output logic             busy,
  output logic             err,
  output logic             done_irq_p,
  output logic             mul_enable_p,
  output logic [NBITS-1:0] mul_a,
  output logic [NBITS-1:0] mul_b,
  output logic [NBITS-1:0] mul_m,
  input  logic [NBITS-1:0] mul_y,
  input  logic             mul_done_irq_p
);

  state_e           state_q, state_d;
  logic [NBITS-1:0] acc_q, acc_d;
  logic [CBITS-1:0] idx_q, idx_d;
  logic [NBITS-1:0] base_q, base_d;
  logic [EBITS-1:0] exp_q, exp_d;
  logic [NBITS-1:0] m_q, m_d;
  logic             err_q, err_d;
  logic [NBITS-1:0] result_q, result_d;
  logic             done_q, done_d;
  logic             mul_en_q, mul_en_d;
  logic [NBITS-1:0] mul_a_q, mul_a_d;
  logic [NBITS-1:0] mul_b_q, mul_b_d;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    base_d   = base_q;
    exp_d    = exp_q;
    m_d      = m_q;
    err_d    = err_q;
    result_d = result_q;
    mul_a_d  = mul_a_q;
    mul_b_d  = mul_b_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start_p) begin
          base_d  = base;
          exp_d   = exp;
          m_d     = m;
          err_d   = 1'b0;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (m_q == '0 || base_q >= m_q) begin
          err_d   = 1'b1;
          state_d = ST_FIN;
        end else if (exp_q == '0) begin
          acc_d   = (m_q == NBITS'(1)) ? '0 : NBITS'(ONE_NBITS);
          state_d = ST_FIN;
        end else begin
          idx_d   = CBITS'(EBITS - 1);
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        // The leading one seeds acc with base, so it never costs a squaring.
        if (exp_q[idx_q]) begin
          acc_d = base_q;
          if (idx_q == '0) begin
            state_d = ST_FIN;
          end else begin
            idx_d   = idx_q - CBITS'(1);
            state_d = ST_SQR_GO;
          end
        end else begin
          idx_d = idx_q - CBITS'(1);
        end
      end
      ST_SQR_GO: state_d = ST_SQR_WAIT;
      ST_SQR_WAIT: begin
        if (mul_done_irq_p) begin
          acc_d = mul_y;
          if (exp_q[idx_q]) begin
            state_d = ST_MUL_GO;
          end else if (idx_q == '0) begin
            state_d = ST_FIN;
          end else begin
            idx_d   = idx_q - CBITS'(1);
            state_d = ST_SQR_GO;
          end
        end
      end
      ST_MUL_GO: state_d = ST_MUL_WAIT;
      ST_MUL_WAIT: begin
        if (mul_done_irq_p) begin
          acc_d = mul_y;
          if (idx_q == '0) begin
            state_d = ST_FIN;
          end else begin
            idx_d   = idx_q - CBITS'(1);
            state_d = ST_SQR_GO;
          end
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Operands are loaded on entry to a GO state and then held untouched
    // until the following GO, which keeps them stable across the wait.
    mul_en_d = (state_d == ST_SQR_GO) || (state_d == ST_MUL_GO);
    if (state_d == ST_SQR_GO) begin
      mul_a_d = acc_d;
      mul_b_d = acc_d;
    end else if (state_d == ST_MUL_GO) begin
      mul_a_d = base_q;
      mul_b_d = acc_d;
    end

    done_d = (state_d == ST_FIN);
    if (state_d == ST_FIN) begin
      result_d = err_d ? '0 : acc_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      idx_q    <= '0;
      base_q   <= '0;
      exp_q    <= '0;
      m_q      <= '0;
      err_q    <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b0;
      mul_en_q <= 1'b0;
      mul_a_q  <= '0;
      mul_b_q  <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      base_q   <= base_d;
      exp_q    <= exp_d;
      m_q      <= m_d;
      err_q    <= err_d;
      result_q <= result_d;
      done_q   <= done_d;
      mul_en_q <= mul_en_d;
      mul_a_q  <= mul_a_d;
      mul_b_q  <= mul_b_d;
    end
  end

  assign result       = result_q;
  assign busy         = (state_q != ST_IDLE);
  assign err          = err_q;
  assign done_irq_p   = done_q;
  assign mul_enable_p = mul_en_q;
  assign mul_a        = mul_a_q;
  assign mul_b        = mul_b_q;
  assign mul_m        = m_q;

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// Bench for mod_exp_ctrl with a behavioural variable-latency multiplier and
// a plain-arithmetic modular power reference.
module tb_mod_exp_ctrl;

  localparam int NB = 8;
  localparam int EB = 8;
  localparam int CB = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_p = 1'b0;
  logic [NB-1:0] base = '0;
  logic [EB-1:0] exp = '0;
  logic [NB-1:0] m = '0;
  logic [NB-1:0] result;
  logic          busy, err, done_irq_p, mul_enable_p;
  logic [NB-1:0] mul_a, mul_b, mul_m;
  logic [NB-1:0] mul_y = '0;
  logic          mul_done_irq_p = 1'b0;

  int errors = 0;
  int checks = 0;

  // multiplier model state
  int            n_ops = 0;
  bit            pending = 0;
  bit            stalled = 0;
  int            stall_op = -1;
  int            lat = 0;
  logic [NB-1:0] prod = '0;

  mod_exp_ctrl #(.NBITS(NB), .EBITS(EB), .CBITS(CB)) dut (
    .clk(clk), .rst_n(rst_n), .start_p(start_p), .base(base), .exp(exp), .m(m),
    .result(result), .busy(busy), .err(err), .done_irq_p(done_irq_p),
    .mul_enable_p(mul_enable_p), .mul_a(mul_a), .mul_b(mul_b), .mul_m(mul_m),
    .mul_y(mul_y), .mul_done_irq_p(mul_done_irq_p)
  );

  always #5 clk = ~clk;

  // Multiplier: 1..4 cycle latency, plus stray completion pulses while idle.
  initial begin
    forever begin
      @(posedge clk); #1;
      mul_done_irq_p = 1'b0;
      if (pending && !stalled) begin
        if (lat == 0) begin
          mul_done_irq_p = 1'b1;
          mul_y = prod;
          pending = 0;
        end else begin
          lat--;
        end
      end else if (!pending && $urandom_range(0, 3) == 0) begin
        mul_done_irq_p = 1'b1;
        mul_y = NB'($urandom);
      end
      if (mul_enable_p === 1'b1) begin
        n_ops++;
        checks++;
        if (pending) begin
          errors++;
          $display("FAIL mul_overlap: launch %0d while a product is outstanding", n_ops);
        end
        checks++;
        if (!(mul_a < mul_m && mul_b < mul_m)) begin
          errors++;
          $display("FAIL mul_operand_range: a=%0d b=%0d must both be below m=%0d", mul_a, mul_b, mul_m);
        end
        prod = (mul_m == '0) ? '0 : NB'((16'(mul_a) * 16'(mul_b)) % 16'(mul_m));
        pending = 1;
        lat = $urandom_range(0, 3);
        if (n_ops == stall_op) stalled = 1;
      end
    end
  end

  function automatic logic [NB-1:0] ref_pow(input logic [NB-1:0] b, input logic [EB-1:0] e,
                                           input logic [NB-1:0] mm);
    longint r;
    if (mm == 0) return '0;
    r = 1 % longint'(mm);
    for (int i = 0; i < int'(e); i++) r = (r * longint'(b)) % longint'(mm);
    return NB'(r);
  endfunction

  function automatic int ref_ops(input logic [EB-1:0] e);
    int bl, pc;
    bl = 0;
    pc = 0;
    for (int i = 0; i < EB; i++) begin
      if (e[i]) begin
        bl = i + 1;
        pc++;
      end
    end
    return (e == 0) ? 0 : (bl - 1) + (pc - 1);
  endfunction

  task automatic run_op(input logic [NB-1:0] b, input logic [EB-1:0] e, input logic [NB-1:0] mm,
                        input bit interfere, input bit fin_start, input string tag);
    logic [NB-1:0] exp_res;
    bit            exp_err, seen, did;
    int            exp_ops, ops0, ndone;
    exp_err = (mm == 0) || (b >= mm);
    exp_res = exp_err ? '0 : ref_pow(b, e, mm);
    exp_ops = exp_err ? 0 : ref_ops(e);
    base = b; exp = e; m = mm; start_p = 1'b1;
    @(posedge clk); #1;
    start_p = 1'b0;
    ops0 = n_ops;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL %s busy_after_start: got %b want 1", tag, busy);
    end
    seen = 0; did = 0; ndone = 0;
    for (int cyc = 0; cyc < 400 && !seen; cyc++) begin
      if (interfere && !did && n_ops > ops0) begin
        start_p = 1'b1; base = ~b; exp = ~e; m = 8'hFF; did = 1;
      end else begin
        start_p = 1'b0;
      end
      @(posedge clk); #1;
      if (done_irq_p === 1'b1) begin
        seen = 1;
        ndone++;
        checks += 3;
        if (result !== exp_res) begin
          errors++;
          $display("FAIL %s result: got %0d want %0d", tag, result, exp_res);
        end
        if (err !== exp_err) begin
          errors++;
          $display("FAIL %s err: got %b want %b", tag, err, exp_err);
        end
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL %s busy_in_done: got %b want 1", tag, busy);
        end
        if (fin_start) start_p = 1'b1;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s done_timeout: no done_irq_p within 400 cycles", tag);
    end
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      start_p = 1'b0;
      if (done_irq_p === 1'b1) ndone++;
      if (k == 0) begin
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL %s busy_after_done: got %b want 0", tag, busy);
        end
      end
    end
    checks += 3;
    if (ndone != 1) begin
      errors++;
      $display("FAIL %s done_count: got %0d want 1", tag, ndone);
    end
    if (n_ops - ops0 != exp_ops) begin
      errors++;
      $display("FAIL %s mul_ops: got %0d want %0d", tag, n_ops - ops0, exp_ops);
    end
    if (result !== exp_res) begin
      errors++;
      $display("FAIL %s result_hold: got %0d want %0d", tag, result, exp_res);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (result !== '0 || busy !== 1'b0 || err !== 1'b0 || done_irq_p !== 1'b0 ||
        mul_enable_p !== 1'b0 || mul_a !== '0 || mul_b !== '0 || mul_m !== '0) begin
      errors++;
      $display("FAIL %s reset_outputs: result=%0d busy=%b err=%b done=%b en=%b a=%0d b=%0d m=%0d want all 0",
               tag, result, busy, err, done_irq_p, mul_enable_p, mul_a, mul_b, mul_m);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("in_reset");
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("after_release");
  endtask

  task automatic test_square_multiply();
    run_op(8'd4, 8'd11, 8'd13, 0, 0, "sqmul_4_11_13");
  endtask

  task automatic test_zero_exp();
    run_op(8'd7, 8'd0, 8'd13, 0, 0, "exp0_m13");
    run_op(8'd0, 8'd0, 8'd1, 0, 0, "exp0_m1");
  endtask

  task automatic test_errors();
    run_op(8'd13, 8'd5, 8'd13, 0, 0, "err_base_eq_m");
    run_op(8'd3, 8'd5, 8'd0, 0, 0, "err_m0");
  endtask

  task automatic test_single_bit();
    run_op(8'd5, 8'd1, 8'd13, 0, 0, "exp1");
    run_op(8'd2, 8'h80, 8'd13, 0, 0, "exp80");
  endtask

  task automatic test_back_to_back();
    run_op(8'd4, 8'd11, 8'd13, 1, 0, "start_while_busy");
    run_op(8'd3, 8'd5, 8'd7, 0, 1, "start_at_fin");
    run_op(8'd6, 8'hFF, 8'd251, 0, 0, "exp_ff");
  endtask

  task automatic test_reset_abort();
    int  ops0;
    bit  bad;
    ops0 = n_ops;
    stall_op = ops0 + 3;
    base = 8'd4; exp = 8'd11; m = 8'd13; start_p = 1'b1;
    @(posedge clk); #1;
    start_p = 1'b0;
    for (int cyc = 0; cyc < 200 && n_ops < ops0 + 3; cyc++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (n_ops < ops0 + 3) begin
      errors++;
      $display("FAIL abort_reach_mul: got %0d launches want 3", n_ops - ops0);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("abort_async");
    @(posedge clk); #1;
    rst_n = 1'b1;
    stalled = 0;
    stall_op = -1;
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (busy !== 1'b0 || done_irq_p !== 1'b0 || mul_enable_p !== 1'b0) bad = 1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL abort_late_pulse: busy/done/enable became active, want all 0");
    end
    check_reset_outputs("abort_after_late_pulse");
    run_op(8'd4, 8'd11, 8'd13, 0, 0, "after_abort");
  endtask

  task automatic test_random();
    logic [NB-1:0] b, mm;
    logic [EB-1:0] e;
    for (int i = 0; i < 25; i++) begin
      mm = NB'($urandom_range(0, 255));
      if (mm == 0 || $urandom_range(0, 7) == 0) b = NB'($urandom);
      else b = NB'($urandom % int'(mm));
      if ($urandom_range(0, 3) == 0) e = EB'($urandom_range(0, 3));
      else e = EB'($urandom);
      run_op(b, e, mm, 0, 0, $sformatf("rand%0d_b%0d_e%0d_m%0d", i, b, e, mm));
    end
  endtask

  initial begin
    test_reset();
    test_square_multiply();
    test_zero_exp();
    test_errors();
    test_single_bit();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
